// File: rtl/exec_stage_md.sv
// exec_stage_md: execute stage with an elastic valid/ready handshake and a multi-cycle
// RV32M unit. ALU ops load the output register on the accept edge. MUL* spend
// MUL_CYCLES cycles in BUSY and DIV/REM spend XLEN cycles there. The result loads
// on the edge that enters DONE, and the following edge returns the FSM to IDLE.
//
// Ports
//   clk, rst                      clock (rising edge); synchronous active-high reset
//   flush                         kills the in-flight M op and any held output
//   in_valid / in_ready           handshake from decode
//   in_rd, in_wen                 destination register and write enable
//   in_alu_sel, in_a_sel, in_b_sel  ALU op and operand muxing
//   in_md_en, in_md_op            M-extension enable and funct3
//   in_rs1, in_rs2, in_imm, in_pc operands, immediate and PC
//   out_valid / out_ready         handshake to the memory stage
//   out_rd, out_wen, out_result, out_rs2, out_return_pc  registered result payload
//   busy                          M unit iterating
module exec_stage_md #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_COUNT  = 32,
    parameter int unsigned REG_BITS   = $clog2(REG_COUNT),
    parameter int unsigned ALU_SEL_W  = 4,
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_BITS-1:0]  in_rd,
    input  logic                 in_wen,
    input  logic [ALU_SEL_W-1:0] in_alu_sel,
    input  logic                 in_a_sel,
    input  logic                 in_b_sel,
    input  logic                 in_md_en,
    input  logic [2:0]           in_md_op,
    input  logic [XLEN-1:0]      in_rs1,
    input  logic [XLEN-1:0]      in_rs2,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [31:0]          in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_BITS-1:0]  out_rd,
    output logic                 out_wen,
    output logic [XLEN-1:0]      out_result,
    output logic [XLEN-1:0]      out_rs2,
    output logic [31:0]          out_return_pc,
    output logic                 busy
);

    localparam int unsigned SH_W    = $clog2(XLEN);
    localparam int unsigned CNT_MAX = (MUL_CYCLES > XLEN) ? MUL_CYCLES : XLEN;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned PROD_W  = 2 * XLEN + 2;

    localparam logic [ALU_SEL_W-1:0] ALU_ADD  = ALU_SEL_W'(0);
    localparam logic [ALU_SEL_W-1:0] ALU_SUB  = ALU_SEL_W'(1);
    localparam logic [ALU_SEL_W-1:0] ALU_SLL  = ALU_SEL_W'(2);
    localparam logic [ALU_SEL_W-1:0] ALU_SLT  = ALU_SEL_W'(3);
    localparam logic [ALU_SEL_W-1:0] ALU_SLTU = ALU_SEL_W'(4);
    localparam logic [ALU_SEL_W-1:0] ALU_XOR  = ALU_SEL_W'(5);
    localparam logic [ALU_SEL_W-1:0] ALU_SRL  = ALU_SEL_W'(6);
    localparam logic [ALU_SEL_W-1:0] ALU_SRA  = ALU_SEL_W'(7);
    localparam logic [ALU_SEL_W-1:0] ALU_OR   = ALU_SEL_W'(8);
    localparam logic [ALU_SEL_W-1:0] ALU_AND  = ALU_SEL_W'(9);

    localparam logic [2:0] MD_MUL   = 3'd0;
    localparam logic [2:0] MD_MULH  = 3'd1;
    localparam logic [2:0] MD_MULHU = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt_r;
    logic [2:0]           md_op_r;
    logic [XLEN-1:0]      a_r;
    logic [XLEN-1:0]      b_r;
    logic [REG_BITS-1:0]  rd_r;
    logic                 wen_r;
    logic [31:0]          ret_pc_r;
    logic [XLEN-1:0]      rem_r;
    logic [XLEN-1:0]      quo_r;
    logic [XLEN-1:0]      dvs_r;

    logic                 accept;

    // Handshake: only IDLE accepts, and only when the output slot frees this edge.
    assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign busy     = (state == BUSY);

    // ALU datapath, evaluated on the incoming instruction.
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] alu_res;

    assign op_a  = in_a_sel ? XLEN'(in_pc) : in_rs1;
    assign op_b  = in_b_sel ? in_imm : in_rs2;
    assign shamt = op_b[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (in_alu_sel)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
            ALU_SLTU: alu_res = XLEN'(op_a < op_b);
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = XLEN'($signed(op_a) >>> shamt);
            ALU_OR:   alu_res = op_a | op_b;
            ALU_AND:  alu_res = op_a & op_b;
            default:  alu_res = '0;
        endcase
    end

    // Divider operand magnitudes at accept time (signed DIV/REM have funct3[0]=0).
    logic            in_div_signed;
    logic [XLEN-1:0] rs1_mag;
    logic [XLEN-1:0] rs2_mag;

    assign in_div_signed = !in_md_op[0];
    assign rs1_mag = (in_div_signed && in_rs1[XLEN-1]) ? (~in_rs1 + XLEN'(1)) : in_rs1;
    assign rs2_mag = (in_div_signed && in_rs2[XLEN-1]) ? (~in_rs2 + XLEN'(1)) : in_rs2;

    // Multiplier on captured operands: one extra bit per side carries the operand sign.
    logic                     mul_a_sgn;
    logic                     mul_b_sgn;
    logic signed [XLEN:0]     mul_a_ext;
    logic signed [XLEN:0]     mul_b_ext;
    logic signed [PROD_W-1:0] mul_full;
    logic [1:0]               mul_unused_hi;
    logic [2*XLEN-1:0]        mul_prod;
    logic [XLEN-1:0]          mul_res;

    assign mul_a_sgn = (md_op_r != MD_MULHU);
    assign mul_b_sgn = (md_op_r == MD_MULH);
    assign mul_a_ext = $signed({mul_a_sgn & a_r[XLEN-1], a_r});
    assign mul_b_ext = $signed({mul_b_sgn & b_r[XLEN-1], b_r});
    assign mul_full  = PROD_W'(mul_a_ext) * PROD_W'(mul_b_ext);
    assign {mul_unused_hi, mul_prod} = mul_full;
    assign mul_res   = (md_op_r == MD_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

    // Restoring divider step: the dividend shifts out of quo_r as quotient bits shift in.
    logic [XLEN+1:0] div_trial;
    logic            div_ge;
    logic            div_unused_bit;
    logic [XLEN-1:0] div_diff;
    logic [XLEN-1:0] div_rem_nx;
    logic [XLEN-1:0] div_quo_nx;

    assign div_trial = {1'b0, rem_r, quo_r[XLEN-1]} - {2'b00, dvs_r};
    assign div_ge    = !div_trial[XLEN+1];
    assign {div_unused_bit, div_diff} = div_trial[XLEN:0];
    assign div_rem_nx = div_ge ? div_diff : {rem_r[XLEN-2:0], quo_r[XLEN-1]};
    assign div_quo_nx = {quo_r[XLEN-2:0], div_ge};

    // Sign fix-up and RV32M special cases, applied to the final iteration's values.
    logic            div_signed_r;
    logic            a_neg;
    logic            b_neg;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] q_final;
    logic [XLEN-1:0] r_final;
    logic [XLEN-1:0] md_res;

    assign div_signed_r = !md_op_r[0];
    assign a_neg    = div_signed_r && a_r[XLEN-1];
    assign b_neg    = div_signed_r && b_r[XLEN-1];
    assign div_zero = (b_r == '0);
    assign div_ovf  = div_signed_r && (a_r == {1'b1, {(XLEN-1){1'b0}}}) && (b_r == '1);

    always_comb begin
        q_final = (a_neg ^ b_neg) ? (~div_quo_nx + XLEN'(1)) : div_quo_nx;
        r_final = a_neg ? (~div_rem_nx + XLEN'(1)) : div_rem_nx;
        if (div_zero) begin
            q_final = '1;
            r_final = a_r;
        end else if (div_ovf) begin
            q_final = a_r;
            r_final = '0;
        end
    end

    assign md_res = md_op_r[2] ? (md_op_r[1] ? r_final : q_final) : mul_res;

    // Stage FSM and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt_r         <= '0;
            md_op_r       <= '0;
            a_r           <= '0;
            b_r           <= '0;
            rd_r          <= '0;
            wen_r         <= 1'b0;
            ret_pc_r      <= '0;
            rem_r         <= '0;
            quo_r         <= '0;
            dvs_r         <= '0;
            out_valid     <= 1'b0;
            out_rd        <= '0;
            out_wen       <= 1'b0;
            out_result    <= '0;
            out_rs2       <= '0;
            out_return_pc <= '0;
        end else if (flush) begin
            state     <= IDLE;
            cnt_r     <= '0;
            out_valid <= 1'b0;
        end else begin
            // Consumption clears the slot; a load below on the same edge overrides it.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_md_en) begin
                            md_op_r  <= in_md_op;
                            a_r      <= in_rs1;
                            b_r      <= in_rs2;
                            rd_r     <= in_rd;
                            wen_r    <= in_wen;
                            ret_pc_r <= in_pc + 32'd4;
                            rem_r    <= '0;
                            quo_r    <= rs1_mag;
                            dvs_r    <= rs2_mag;
                            cnt_r    <= in_md_op[2] ? CNT_W'(XLEN) : CNT_W'(MUL_CYCLES);
                            state    <= BUSY;
                        end else begin
                            out_valid     <= 1'b1;
                            out_rd        <= in_rd;
                            out_wen       <= in_wen;
                            out_result    <= alu_res;
                            out_rs2       <= in_rs2;
                            out_return_pc <= in_pc + 32'd4;
                        end
                    end
                end
                BUSY: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (md_op_r[2]) begin
                        rem_r <= div_rem_nx;
                        quo_r <= div_quo_nx;
                    end
                    // Last BUSY cycle: the result loads on the edge entering DONE.
                    if (cnt_r == CNT_W'(1)) begin
                        state         <= DONE;
                        out_valid     <= 1'b1;
                        out_rd        <= rd_r;
                        out_wen       <= wen_r;
                        out_result    <= md_res;
                        out_rs2       <= b_r;
                        out_return_pc <= ret_pc_r;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
